// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute stage of the pipelined MIPS core.
// Drives register-file read addresses, bypasses a same-cycle writeback,
// detects load-use hazards against the instruction in EX, and captures the
// resolved operands into the ID/EX pipeline register.
module id_ex_stage #(
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_wa,
   input  logic              in_uses_rt,
   input  logic              in_memread,
   input  logic              in_regwrite,
   input  logic [31:0]       in_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic [4:0]        ra1,
   output logic [4:0]        ra2,
   input  logic [31:0]       rd1,
   input  logic [31:0]       rd2,
   input  logic              wb_en,
   input  logic [4:0]        wb_wa,
   input  logic [31:0]       wb_wd,
   input  logic              flush,
   input  logic              ext_hold,
   output logic              stall,
   output logic              out_valid,
   output logic              out_memread,
   output logic              out_regwrite,
   output logic [31:0]       out_a,
   output logic [31:0]       out_b,
   output logic [31:0]       out_imm,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_wa,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  hazard_cnt
);

   logic [31:0] a_byp;
   logic [31:0] b_byp;
   logic        lu;

   assign ra1 = in_rs;
   assign ra2 = in_rt;

   // A flush overrides everything else, so it never stalls the front end.
   assign stall = !flush && (ext_hold || lu);

   // Writeback bypass of the register file and load-use detection against EX
   always_comb begin
      a_byp = rd1;
      b_byp = rd2;
      if (wb_en && (wb_wa != 5'd0) && (wb_wa == in_rs))
         a_byp = wb_wd;
      if (wb_en && (wb_wa != 5'd0) && (wb_wa == in_rt))
         b_byp = wb_wd;
      lu = in_valid && out_valid && out_memread && out_regwrite &&
           (out_wa != 5'd0) &&
           ((out_wa == in_rs) || (in_uses_rt && (out_wa == in_rt)));
   end

   // ID/EX register: flush or load-use inserts a bubble, ext_hold freezes, else load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_memread  <= 1'b0;
         out_regwrite <= 1'b0;
         out_a        <= '0;
         out_b        <= '0;
         out_imm      <= '0;
         out_rs       <= '0;
         out_rt       <= '0;
         out_wa       <= '0;
         out_ctrl     <= '0;
         hazard_cnt   <= '0;
      end else if (flush || (!ext_hold && lu)) begin
         out_valid    <= 1'b0;
         out_memread  <= 1'b0;
         out_regwrite <= 1'b0;
         out_a        <= '0;
         out_b        <= '0;
         out_imm      <= '0;
         out_rs       <= '0;
         out_rt       <= '0;
         out_wa       <= '0;
         out_ctrl     <= '0;
         if (!flush && (hazard_cnt != {CNT_W{1'b1}}))
            hazard_cnt <= hazard_cnt + CNT_W'(1);
      end else if (!ext_hold) begin
         out_valid    <= in_valid;
         out_memread  <= in_valid & in_memread;
         out_regwrite <= in_valid & in_regwrite;
         out_a        <= a_byp;
         out_b        <= b_byp;
         out_imm      <= in_imm;
         out_rs       <= in_rs;
         out_rt       <= in_rt;
         out_wa       <= in_wa;
         out_ctrl     <= in_ctrl;
      end
   end

endmodule
